// File: rtl/adma_as_atx_split.sv
// Purpose: split one DMA TX descriptor into AXI address transactions (burst- and 4KB-bounded).
// Latency: descriptor accepted -> first ATX valid next cycle; one ATX per cycle while credit allows.
// Backpressure: atx_vld held stable until atx_rdy; issue stalls at ATX_NUM_OSTD outstanding ATXs.
module adma_as_atx_split #(
    parameter int ADDR_W        = 32,
    parameter int DMA_LENGTH_W  = 16,
    parameter int DATA_BYTES    = 4,
    parameter int ATX_MAX_BEATS = 16,
    parameter int ATX_NUM_OSTD  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  tx_vld,
    output logic                                  tx_rdy,
    input  logic [ADDR_W-1:0]                     tx_addr,
    input  logic [DMA_LENGTH_W-1:0]               tx_len,
    output logic                                  atx_vld,
    input  logic                                  atx_rdy,
    output logic [ADDR_W-1:0]                     atx_addr,
    output logic [7:0]                            atx_len,
    output logic                                  atx_start,
    output logic                                  atx_start_last,
    input  logic                                  atx_done,
    output logic [$clog2(ATX_NUM_OSTD+1)-1:0]     ostd_cnt
);

    localparam int CNT_W = $clog2(ATX_NUM_OSTD + 1);
    localparam int REM_W = DMA_LENGTH_W + 1;
    localparam int OFF_W = $clog2(DATA_BYTES);
    // Beat arithmetic width: wide enough for both the remaining count and the 4KB page term.
    localparam int MW    = (REM_W > 13) ? REM_W : 13;
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(DATA_BYTES - 1);

    typedef enum logic {
        S_IDLE,
        S_SPLIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_cur_addr;
    logic [REM_W-1:0]   r_remain;
    logic [CNT_W-1:0]   r_ostd_cnt;

    logic [MW-1:0]      w_bnd_beats;
    logic [MW-1:0]      w_rem_ext;
    logic [MW-1:0]      w_beats;
    logic               w_split;
    logic               w_credit_ok;
    logic               w_last;
    logic               w_hs;
    logic               w_tx_acc;
    logic               w_dec;

    assign w_split     = (r_state == S_SPLIT);
    assign w_rem_ext   = MW'(r_remain);
    // Beats left before the next 4KB page; never zero since the address is beat-aligned.
    assign w_bnd_beats = MW'((13'd4096 - {1'b0, r_cur_addr[11:0]}) >> OFF_W);

    // Beats in the current ATX: smallest of remaining, burst limit and page limit.
    always_comb begin
        w_beats = w_rem_ext;
        if (MW'(ATX_MAX_BEATS) < w_beats) begin
            w_beats = MW'(ATX_MAX_BEATS);
        end
        if (w_bnd_beats < w_beats) begin
            w_beats = w_bnd_beats;
        end
    end

    assign w_last      = (w_rem_ext == w_beats);
    // Registered count only: a done in this cycle frees the credit next cycle, keeping vld stable.
    assign w_credit_ok = (r_ostd_cnt < CNT_W'(ATX_NUM_OSTD));
    assign w_hs        = atx_vld & atx_rdy;
    assign w_tx_acc    = tx_vld & tx_rdy;
    assign w_dec       = atx_done & (r_ostd_cnt != '0);

    assign tx_rdy         = (r_state == S_IDLE);
    assign atx_vld        = w_split & w_credit_ok;
    assign atx_addr       = w_split ? r_cur_addr : '0;
    assign atx_len        = w_split ? 8'(w_beats - MW'(1)) : 8'd0;
    assign atx_start_last = w_split & w_last;
    assign atx_start      = w_hs;
    assign ostd_cnt       = r_ostd_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave IDLE on descriptor accept, return after the final ATX handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_tx_acc) w_state_nxt = S_SPLIT;
            S_SPLIT: if (w_hs && w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address / remaining-beat tracking: load on accept, advance on each ATX handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr <= '0;
            r_remain   <= '0;
        end else if (w_tx_acc) begin
            r_cur_addr <= tx_addr & ~LOW_MASK;
            r_remain   <= REM_W'(tx_len) + REM_W'(1);
        end else if (w_hs) begin
            r_cur_addr <= r_cur_addr + (ADDR_W'(w_beats) << OFF_W);
            r_remain   <= r_remain - REM_W'(w_beats);
        end
    end

    // Outstanding-ATX credit counter; a done with nothing outstanding is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ostd_cnt <= '0;
        end else begin
            r_ostd_cnt <= r_ostd_cnt + CNT_W'(w_hs) - CNT_W'(w_dec);
        end
    end

endmodule

// File: tb/tb_adma_as_atx_split.sv
// Directed bench for adma_as_atx_split with hand-computed ATX sequences.
// Inputs driven 1ns after the rising edge, outputs sampled 1ns later.
// Checks use immediate assertions; one summary line at the end.
module tb_adma_as_atx_split;

    logic        clk;
    logic        rst_n;
    logic        tx_vld;
    logic        tx_rdy;
    logic [31:0] tx_addr;
    logic [15:0] tx_len;
    logic        atx_vld;
    logic        atx_rdy;
    logic [31:0] atx_addr;
    logic [7:0]  atx_len;
    logic        atx_start;
    logic        atx_start_last;
    logic        atx_done;
    logic [2:0]  ostd_cnt;

    int checks   = 0;
    int failures = 0;

    adma_as_atx_split dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tx_vld         (tx_vld),
        .tx_rdy         (tx_rdy),
        .tx_addr        (tx_addr),
        .tx_len         (tx_len),
        .atx_vld        (atx_vld),
        .atx_rdy        (atx_rdy),
        .atx_addr       (atx_addr),
        .atx_len        (atx_len),
        .atx_start      (atx_start),
        .atx_start_last (atx_start_last),
        .atx_done       (atx_done),
        .ostd_cnt       (ostd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1ns after the edge so inputs can be driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_atx(input string tag, input logic [31:0] addr, input logic [7:0] len,
                             input logic last, input logic start);
        check({tag, ".vld"},   {31'd0, atx_vld}, 32'd1);
        check({tag, ".addr"},  atx_addr, addr);
        check({tag, ".len"},   {24'd0, atx_len}, {24'd0, len});
        check({tag, ".last"},  {31'd0, atx_start_last}, {31'd0, last});
        check({tag, ".start"}, {31'd0, atx_start}, {31'd0, start});
    endtask

    // Return every credit and let any unfinished TX run out; bounded.
    task automatic drain(input string tag);
        atx_done = 1'b1;
        atx_rdy  = 1'b1;
        tx_vld   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (tx_rdy && ostd_cnt == 3'd0) break;
            tick();
        end
        atx_done = 1'b0;
        #1;
        check({tag, ".drain_rdy"},  {31'd0, tx_rdy}, 32'd1);
        check({tag, ".drain_ostd"}, {29'd0, ostd_cnt}, 32'd0);
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_vld   = 1'b0;
        tx_addr  = 32'd0;
        tx_len   = 16'd0;
        atx_rdy  = 1'b0;
        atx_done = 1'b0;
        #12;
        // Reset state
        check("rst.tx_rdy", {31'd0, tx_rdy}, 32'd1);
        check("rst.vld",    {31'd0, atx_vld}, 32'd0);
        check("rst.addr",   atx_addr, 32'd0);
        check("rst.len",    {24'd0, atx_len}, 32'd0);
        check("rst.last",   {31'd0, atx_start_last}, 32'd0);
        check("rst.start",  {31'd0, atx_start}, 32'd0);
        check("rst.ostd",   {29'd0, ostd_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Defaults: 40 beats at 0x1000 -> 16 + 16 + 8
        tx_vld = 1'b1; tx_addr = 32'h1000; tx_len = 16'd39; atx_rdy = 1'b1;
        tick();
        tx_vld = 1'b0; #1;
        check("def.tx_rdy", {31'd0, tx_rdy}, 32'd0);
        check_atx("def.a1", 32'h1000, 8'd15, 1'b0, 1'b1);
        tick();
        atx_done = 1'b1; #1;
        check_atx("def.a2", 32'h1040, 8'd15, 1'b0, 1'b1);
        check("def.ostd1", {29'd0, ostd_cnt}, 32'd1);
        tick(); #1;
        check_atx("def.a3", 32'h1080, 8'd7, 1'b1, 1'b1);
        check("def.ostd_same", {29'd0, ostd_cnt}, 32'd1);
        tick(); #1;
        check("def.idle_rdy",   {31'd0, tx_rdy}, 32'd1);
        check("def.idle_vld",   {31'd0, atx_vld}, 32'd0);
        check("def.idle_start", {31'd0, atx_start}, 32'd0);
        tick();
        atx_done = 1'b0; #1;
        check("def.ostd0", {29'd0, ostd_cnt}, 32'd0);

        // 4KB crossing, aligned and unaligned start
        for (int k = 0; k < 2; k++) begin
            tx_vld = 1'b1; tx_addr = (k == 0) ? 32'h1FF8 : 32'h1FFB; tx_len = 16'd9;
            tick();
            tx_vld = 1'b0; #1;
            check_atx("x4k.a1", 32'h1FF8, 8'd1, 1'b0, 1'b1);
            tick(); #1;
            check_atx("x4k.a2", 32'h2000, 8'd7, 1'b1, 1'b1);
            tick(); #1;
            check("x4k.rdy",  {31'd0, tx_rdy}, 32'd1);
            check("x4k.ostd", {29'd0, ostd_cnt}, 32'd2);
            drain("x4k");
        end

        // Credit throttle: 100 beats, no done
        tx_vld = 1'b1; tx_addr = 32'h1000; tx_len = 16'd99;
        tick();
        tx_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_atx("thr.a", 32'h1000 + 32'(i) * 32'h40, 8'd15, 1'b0, 1'b1);
            tick();
        end
        #1;
        check("thr.full_vld",   {31'd0, atx_vld}, 32'd0);
        check("thr.full_start", {31'd0, atx_start}, 32'd0);
        check("thr.full_ostd",  {29'd0, ostd_cnt}, 32'd4);
        tick();
        atx_done = 1'b1; #1;
        check("thr.nobypass", {31'd0, atx_vld}, 32'd0);
        tick(); #1;
        check("thr.ostd3", {29'd0, ostd_cnt}, 32'd3);
        check_atx("thr.a5", 32'h1100, 8'd15, 1'b0, 1'b1);
        tick();
        atx_done = 1'b0; #1;
        check("thr.same_cycle_ostd", {29'd0, ostd_cnt}, 32'd3);
        check_atx("thr.a6", 32'h1140, 8'd15, 1'b0, 1'b1);
        tick(); #1;
        check("thr.full2_vld", {31'd0, atx_vld}, 32'd0);
        check("thr.full2_ostd", {29'd0, ostd_cnt}, 32'd4);
        drain("thr");

        // Single beat, then a held descriptor accepted only back in IDLE
        tx_vld = 1'b1; tx_addr = 32'h40; tx_len = 16'd0;
        tick();
        tx_addr = 32'h80; tx_len = 16'd1; #1;
        check("b2b.busy_rdy", {31'd0, tx_rdy}, 32'd0);
        check_atx("b2b.a1", 32'h40, 8'd0, 1'b1, 1'b1);
        tick(); #1;
        check("b2b.idle_rdy", {31'd0, tx_rdy}, 32'd1);
        check("b2b.idle_vld", {31'd0, atx_vld}, 32'd0);
        tick();
        tx_vld = 1'b0; #1;
        check("b2b.busy_rdy2", {31'd0, tx_rdy}, 32'd0);
        check_atx("b2b.a2", 32'h80, 8'd1, 1'b1, 1'b1);
        tick();
        drain("b2b");

        // Backpressure on the second ATX
        tx_vld = 1'b1; tx_addr = 32'h0; tx_len = 16'd47;
        tick();
        tx_vld = 1'b0; #1;
        check_atx("bp.a1", 32'h0, 8'd15, 1'b0, 1'b1);
        tick();
        atx_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_atx("bp.hold", 32'h40, 8'd15, 1'b0, 1'b0);
            check("bp.ostd", {29'd0, ostd_cnt}, 32'd1);
            tick();
        end
        atx_rdy = 1'b1; #1;
        check_atx("bp.a2", 32'h40, 8'd15, 1'b0, 1'b1);
        tick(); #1;
        check_atx("bp.a3", 32'h80, 8'd15, 1'b1, 1'b1);
        tick();
        drain("bp");
        atx_done = 1'b1;
        tick();
        atx_done = 1'b0; #1;
        check("bp.no_underflow", {29'd0, ostd_cnt}, 32'd0);

        // Reset in the middle of a 3-ATX TX
        tx_vld = 1'b1; tx_addr = 32'h0; tx_len = 16'd47;
        tick();
        tx_vld = 1'b0; #1;
        check_atx("rmid.a1", 32'h0, 8'd15, 1'b0, 1'b1);
        tick();
        rst_n = 1'b0; #1;
        check("rmid.rdy",   {31'd0, tx_rdy}, 32'd1);
        check("rmid.vld",   {31'd0, atx_vld}, 32'd0);
        check("rmid.start", {31'd0, atx_start}, 32'd0);
        check("rmid.addr",  atx_addr, 32'd0);
        check("rmid.len",   {24'd0, atx_len}, 32'd0);
        check("rmid.last",  {31'd0, atx_start_last}, 32'd0);
        check("rmid.ostd",  {29'd0, ostd_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); #1;
        check("rmid.post_vld",   {31'd0, atx_vld}, 32'd0);
        check("rmid.post_start", {31'd0, atx_start}, 32'd0);
        check("rmid.post_rdy",   {31'd0, tx_rdy}, 32'd1);
        tx_vld = 1'b1; tx_addr = 32'h0; tx_len = 16'd3;
        tick();
        tx_vld = 1'b0; #1;
        check_atx("rmid.new", 32'h0, 8'd3, 1'b1, 1'b1);
        tick(); #1;
        check("rmid.new_idle", {31'd0, tx_rdy}, 32'd1);
        drain("rmid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
